// File: rtl/yousei_os_pkg.sv
// Shared definitions for the YouseiOS process-control block: OS opcodes,
// scheduler state encoding and the kernel PID.
package yousei_os_pkg;

    localparam logic [5:0] OP_INPUT       = 6'b001000;
    localparam logic [5:0] OP_EMIT_MSG    = 6'b011010;
    localparam logic [5:0] OP_ROUND_ROBIN = 6'b011011;
    localparam logic [5:0] OP_SET_PID     = 6'b011100;
    localparam logic [5:0] OP_CREATE_FILE = 6'b011101;
    localparam logic [5:0] OP_HD_READ     = 6'b011111;
    localparam logic [5:0] OP_KERNEL_SWAP = 6'b100001;

    localparam int PID_KERNEL = 0;

    typedef enum logic [1:0] {
        ST_KERNEL  = 2'd0,
        ST_USER    = 2'd1,
        ST_BLOCKED = 2'd2
    } sched_state_t;

    function automatic logic [5:0] get_opcode(input logic [31:0] instr_word);
        return instr_word[31:26];
    endfunction

endpackage

// File: rtl/msg_fifo.sv
// Message FIFO: circular buffer with read/write pointers and an occupancy
// count. A push into a full FIFO is accepted only when a pop happens in the
// same cycle; otherwise it is dropped and the sticky overflow flag is set.
module msg_fifo #(
    parameter int MSG_W     = 5,
    parameter int MSG_DEPTH = 4
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_push,
    input  logic [MSG_W-1:0] i_data,
    input  logic             i_ready,
    output logic [MSG_W-1:0] o_data,
    output logic             o_valid,
    output logic             o_overflow
);

    localparam int AW = (MSG_DEPTH > 1) ? $clog2(MSG_DEPTH) : 1;

    logic [MSG_W-1:0] r_mem [MSG_DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             r_overflow;

    logic w_empty;
    logic w_full;
    logic w_pop;
    logic w_push_ok;
    logic w_drop;

    assign w_empty   = (r_count == '0);
    assign w_full    = (r_count == (AW+1)'(MSG_DEPTH));
    assign w_pop     = !w_empty && i_ready;
    assign w_push_ok = i_push && (!w_full || w_pop);
    assign w_drop    = i_push && w_full && !w_pop;

    // Storage write; contents need no reset since count gates visibility.
    always_ff @(posedge i_clk) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    // Pointer, occupancy and sticky overflow bookkeeping.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_push_ok && !w_pop) begin
                r_count <= r_count + 1'b1;
            end else if (!w_push_ok && w_pop) begin
                r_count <= r_count - 1'b1;
            end
            if (w_drop) begin
                r_overflow <= 1'b1;
            end
        end
    end

    assign o_data     = r_mem[r_rd_ptr];
    assign o_valid    = !w_empty;
    assign o_overflow = r_overflow;

endmodule

// File: rtl/os_sched_ctrl.sv
// YouseiOS process-control block: OS opcode decode, round-robin scheduler
// with programmable quantum, input-block state, kernel swap, message FIFO
// and memory-write / page-update strobes.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// ST_KERNEL  | kernel/BIOS running, pid_out = 0, waits for RR or SET_PID
// ST_USER    | user PID running, slice counter decrements every cycle
// ST_BLOCKED | user PID waiting on INPUT, counter frozen, pid_out held
//
// preempt is high during the USER cycle whose counter has reached zero,
// i.e. the final cycle of the slice; pid_out drops to 0 after it.
module os_sched_ctrl
    import yousei_os_pkg::*;
#(
    parameter int PID_W     = 5,
    parameter int N_PROC    = 4,
    parameter int QUANTUM   = 16,
    parameter int MSG_DEPTH = 4,
    parameter int MSG_W     = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [31:0]       instr,
    input  logic [PID_W-1:0]  pid_data,
    input  logic              save_page,
    input  logic [N_PROC-1:0] proc_alive,
    output logic [PID_W-1:0]  pid_out,
    output logic              preempt,
    output logic [MSG_W-1:0]  msg_data,
    output logic              msg_valid,
    input  logic              msg_ready,
    output logic              msg_overflow,
    output logic              page_update,
    output logic              mem_write
);

    localparam int              CNT_W    = (QUANTUM > 2) ? $clog2(QUANTUM) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(QUANTUM - 1);

    sched_state_t      r_state;
    sched_state_t      w_state_nxt;
    logic [PID_W-1:0]  r_pid;
    logic [PID_W-1:0]  w_pid_nxt;
    logic [PID_W-1:0]  r_last_pid;
    logic [PID_W-1:0]  w_last_nxt;
    logic [CNT_W-1:0]  r_cnt;
    logic [CNT_W-1:0]  w_cnt_nxt;
    logic              r_preempt;
    logic              w_preempt_nxt;
    logic              r_mem_write;

    logic [5:0]        w_op;
    logic              w_rr_hit;
    logic [PID_W-1:0]  w_rr_pid;
    int                w_rr_idx;
    logic [N_PROC-1:0] w_rr_sh;
    logic              w_pid_ok;
    logic              w_unused;

    assign w_op     = get_opcode(instr);
    assign w_pid_ok = (pid_data != '0) && (int'(pid_data) <= N_PROC);
    assign w_unused = ^instr[25:MSG_W];

    // Round-robin search: first alive slot after last_pid, wrapping around.
    always_comb begin
        w_rr_hit = 1'b0;
        w_rr_pid = '0;
        w_rr_idx = 0;
        w_rr_sh  = '0;
        for (int k = 1; k <= N_PROC; k++) begin
            w_rr_idx = int'(r_last_pid) + k - 1;
            if (w_rr_idx >= N_PROC) begin
                w_rr_idx = w_rr_idx - N_PROC;
            end
            w_rr_sh = proc_alive >> w_rr_idx;
            if (!w_rr_hit && w_rr_sh[0]) begin
                w_rr_hit = 1'b1;
                w_rr_pid = PID_W'(w_rr_idx + 1);
            end
        end
    end

    // Scheduler next-state: swap beats INPUT, INPUT beats slice expiry.
    always_comb begin
        w_state_nxt = r_state;
        w_pid_nxt   = r_pid;
        w_last_nxt  = r_last_pid;
        w_cnt_nxt   = r_cnt;
        unique case (r_state)
            ST_KERNEL: begin
                if (w_op == OP_ROUND_ROBIN) begin
                    if (w_rr_hit) begin
                        w_state_nxt = ST_USER;
                        w_pid_nxt   = w_rr_pid;
                        w_last_nxt  = w_rr_pid;
                        w_cnt_nxt   = CNT_LOAD;
                    end
                end else if (w_op == OP_SET_PID && w_pid_ok) begin
                    w_state_nxt = ST_USER;
                    w_pid_nxt   = pid_data;
                    w_last_nxt  = pid_data;
                    w_cnt_nxt   = CNT_LOAD;
                end
            end
            ST_USER: begin
                if (w_op == OP_KERNEL_SWAP) begin
                    w_state_nxt = ST_KERNEL;
                    w_pid_nxt   = PID_W'(PID_KERNEL);
                    w_cnt_nxt   = '0;
                end else if (w_op == OP_INPUT) begin
                    // Expiry coinciding with INPUT parks at zero; the slice
                    // ends on the first USER cycle after release.
                    w_state_nxt = ST_BLOCKED;
                    if (r_cnt != '0) begin
                        w_cnt_nxt = r_cnt - 1'b1;
                    end
                end else if (r_cnt == '0) begin
                    w_state_nxt = ST_KERNEL;
                    w_pid_nxt   = PID_W'(PID_KERNEL);
                end else begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end
            end
            ST_BLOCKED: begin
                if (w_op == OP_KERNEL_SWAP) begin
                    w_state_nxt = ST_KERNEL;
                    w_pid_nxt   = PID_W'(PID_KERNEL);
                    w_cnt_nxt   = '0;
                end else if (w_op != OP_INPUT) begin
                    w_state_nxt = ST_USER;
                end
            end
            default: begin
                w_state_nxt = ST_KERNEL;
                w_pid_nxt   = PID_W'(PID_KERNEL);
                w_cnt_nxt   = '0;
            end
        endcase
        w_preempt_nxt = (w_state_nxt == ST_USER) && (w_cnt_nxt == '0);
    end

    // Scheduler state and registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= ST_KERNEL;
            r_pid       <= PID_W'(PID_KERNEL);
            r_last_pid  <= PID_W'(PID_KERNEL);
            r_cnt       <= '0;
            r_preempt   <= 1'b0;
            r_mem_write <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_pid       <= w_pid_nxt;
            r_last_pid  <= w_last_nxt;
            r_cnt       <= w_cnt_nxt;
            r_preempt   <= w_preempt_nxt;
            r_mem_write <= (w_op == OP_HD_READ);
        end
    end

    msg_fifo #(
        .MSG_W     (MSG_W),
        .MSG_DEPTH (MSG_DEPTH)
    ) u_msg_fifo (
        .i_clk      (clk),
        .i_rst_n    (reset),
        .i_push     (w_op == OP_EMIT_MSG),
        .i_data     (instr[MSG_W-1:0]),
        .i_ready    (msg_ready),
        .o_data     (msg_data),
        .o_valid    (msg_valid),
        .o_overflow (msg_overflow)
    );

    assign pid_out     = r_pid;
    assign preempt     = r_preempt;
    assign mem_write   = r_mem_write;
    assign page_update = save_page || (w_op == OP_CREATE_FILE);

endmodule

// File: doc/os_sched_ctrl.md
# os_sched_ctrl

Parametrised process-control block for the YouseiOS CPU. It decodes OS opcodes from the current instruction and runs a multi-slot round-robin scheduler with a programmable quantum, an input-block state and explicit kernel swap. It also buffers emitted messages in a FIFO with a valid/ready output handshake, and drives the page-update and HD-read memory-write strobes. It sits beside the control unit; `pid_out` feeds page translation and the register-bank selector.

## Interface
- PID_W, 5, PID width; PID 0 = kernel/BIOS
- N_PROC, 4, user slots, PIDs 1..N_PROC (N_PROC < 2^PID_W)
- QUANTUM, 16, cycles per user time slice (≥2)
- MSG_DEPTH, 4, message FIFO depth, power of 2
- MSG_W, 5, message width
---
- clk  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-low
- instr  in  32  current instruction; opcode = instr[31:26]
- pid_data  in  PID_W  PID operand for SET_PID
- save_page  in  1  page save request
- proc_alive  in  N_PROC  bit i set = PID i+1 runnable
- pid_out  out  PID_W  running PID, registered
- preempt  out  1  one-cycle pulse on quantum expiry
- msg_data  out  MSG_W  FIFO head
- msg_valid  out  1  FIFO non-empty
- msg_ready  in  1  consumer accepts head
- msg_overflow  out  1  sticky: push dropped while full
- page_update  out  1  combinational
- mem_write  out  1  registered HD_READ strobe

## Operation
- Opcodes: EMIT_MSG 011010, ROUND_ROBIN 011011, SET_PID 011100, CREATE_FILE 011101, HD_READ 011111, INPUT 001000, KERNEL_SWAP 100001.
- FSM states: KERNEL, USER, BLOCKED. Reset → KERNEL, pid_out=0, last_pid=0, counter=0, FIFO empty, all outputs 0.
- KERNEL + ROUND_ROBIN: search proc_alive starting at slot after last_pid, wrapping. First hit → pid_out, last_pid; counter=QUANTUM-1; → USER. No hit → stay KERNEL.
- KERNEL + SET_PID: pid_data in 1..N_PROC → pid_out=last_pid=pid_data, counter=QUANTUM-1, → USER. Otherwise ignored.
- USER: counter decrements each cycle. At counter==0: preempt=1 for one cycle, pid_out=0, → KERNEL; last_pid is kept.
- USER + INPUT → BLOCKED. BLOCKED: counter frozen, pid_out held. Any opcode other than INPUT → USER next cycle, and decrementing resumes.
- KERNEL_SWAP (USER or BLOCKED) → KERNEL, pid_out=0, counter=0, no preempt pulse.
- Priority: KERNEL_SWAP > INPUT > expiry. Expiry coinciding with INPUT → BLOCKED with counter=0; expires on the first USER cycle after release.
- ROUND_ROBIN/SET_PID outside KERNEL are ignored.
- EMIT_MSG pushes instr[MSG_W-1:0]. Pop occurs on msg_valid&msg_ready. Push when full is allowed only with a simultaneous pop; otherwise the push is dropped and msg_overflow set until reset.
- mem_write = 1 exactly for the cycle after an HD_READ instruction cycle.
- page_update = save_page | (opcode==CREATE_FILE), no register.

## Timing
- pid_out, preempt, mem_write, FSM all update on the clk edge after the instruction cycle: latency 1.
- User slice is exactly QUANTUM cycles of pid_out≠0 when not blocked. preempt asserts in the last cycle, and pid_out=0 follows.
- FIFO: push at edge N → msg_valid high after edge N. Head changes the edge after a pop. Simultaneous push/pop on empty: push, no pop.
- reset low mid-slice: immediate return to reset values, FIFO flushed, overflow cleared.

## Structure
- Package `yousei_os_pkg`: opcode constants, FSM state enum, PID_KERNEL=0.
- Sub-module `msg_fifo` (parametrised MSG_W/MSG_DEPTH, pointer + count, full/empty). Scheduler FSM and round-robin search live in the top.

## Test plan
- Reset, proc_alive=4'b0101, ROUND_ROBIN → pid_out=1 for 16 cycles, preempt pulse on cycle 16, pid_out=0; second ROUND_ROBIN → pid_out=3.
- SET_PID pid_data=2, then INPUT for 5 cycles mid-slice → counter frozen; total pid_out=2 time = 16+5 cycles.
- KERNEL_SWAP at slice cycle 7 → pid_out=0 next cycle, no preempt; ROUND_ROBIN with proc_alive=0 → stays 0.
- 5 EMIT_MSG (values 1..5), msg_ready=0 → 4 stored, msg_overflow=1; drain → 1,2,3,4 in order, msg_valid drops.
- HD_READ → mem_write one cycle later for one cycle; CREATE_FILE or save_page → page_update same cycle.
- Assert reset low mid-slice with FIFO non-empty → pid_out=0, msg_valid=0, overflow=0 immediately.
